// File: rtl/umai_mem_responder_pkg.sv
// Shared widths, FSM encodings and arbiter priority values for the UMAI memory responder.
package umai_mem_responder_pkg;

    localparam int UmaiAddrWidth     = 32;
    localparam int UmaiLenWidth      = 6;
    localparam int UmaiDataWidth     = 512;
    localparam int UmaiBeatBytesLog2 = 6;

    typedef enum logic [1:0] {
        RSP_IDLE  = 2'd0,
        RSP_WRITE = 2'd1,
        RSP_READ  = 2'd2
    } umai_rsp_state_e;

    // Plain vector encodings so the state register stays a legacy-friendly logic [1:0]
    localparam logic [1:0] StIdle  = RSP_IDLE;
    localparam logic [1:0] StWrite = RSP_WRITE;
    localparam logic [1:0] StRead  = RSP_READ;

    localparam logic PrioWr = 1'b0;
    localparam logic PrioRd = 1'b1;

endpackage

// File: rtl/umai_mem_responder_if.sv
// UMAI command/data channel bundle: master drives commands, write data and rready.
interface umai_mem_responder_if;
    import umai_mem_responder_pkg::*;

    logic                     wcmd_valid;
    logic                     wcmd_ready;
    logic [UmaiAddrWidth-1:0] wcmd_addr;
    logic [UmaiLenWidth-1:0]  wcmd_len;
    logic                     rcmd_valid;
    logic                     rcmd_ready;
    logic [UmaiAddrWidth-1:0] rcmd_addr;
    logic [UmaiLenWidth-1:0]  rcmd_len;
    logic                     wvalid;
    logic                     wready;
    logic [UmaiDataWidth-1:0] wdata;
    logic                     rvalid;
    logic                     rready;
    logic [UmaiDataWidth-1:0] rdata;

    modport master (
        output wcmd_valid, wcmd_addr, wcmd_len,
        output rcmd_valid, rcmd_addr, rcmd_len,
        output wvalid, wdata, rready,
        input  wcmd_ready, rcmd_ready, wready, rvalid, rdata
    );

    modport slave (
        input  wcmd_valid, wcmd_addr, wcmd_len,
        input  rcmd_valid, rcmd_addr, rcmd_len,
        input  wvalid, wdata, rready,
        output wcmd_ready, rcmd_ready, wready, rvalid, rdata
    );

endinterface

// File: rtl/umai_mem_responder_mem.sv
// Beat storage: flop array with one write port and one combinational read port.
// Swapping in an SRAM macro adds one cycle of read latency to the issue path.
module umai_mem_responder_mem
    import umai_mem_responder_pkg::*;
#(
    parameter int DepthLog2 = 6
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DepthLog2-1:0]     waddr,
    input  logic [UmaiDataWidth-1:0] wdata,
    input  logic [DepthLog2-1:0]     raddr,
    output logic [UmaiDataWidth-1:0] rdata
);

    localparam int Depth = 1 << DepthLog2;

    logic [UmaiDataWidth-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/umai_mem_responder.sv
// UMAI responder: arbitrates write/read commands, stores write beats and streams
// read beats back through a registered output with rvalid/rready backpressure.
module umai_mem_responder
    import umai_mem_responder_pkg::*;
#(
    parameter int DepthLog2 = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    umai_mem_responder_if.slave  umai,
    output logic                 o_busy
);

    logic [1:0]               state;
    logic                     prio;
    logic [DepthLog2-1:0]     ptr;
    logic [UmaiLenWidth-1:0]  cnt;
    logic                     vld_p1;
    logic [UmaiDataWidth-1:0] rdata_p1;
    logic [UmaiDataWidth-1:0] mem_rdata;

    logic idle;
    logic wr_acc;
    logic rd_acc;
    logic wr_beat;
    logic rd_issue;
    logic unused_addr_bits;

    function automatic logic [DepthLog2-1:0] beat_index(input logic [UmaiAddrWidth-1:0] addr);
        return addr[UmaiBeatBytesLog2 +: DepthLog2];
    endfunction

    // Only the beat-index field of an address is meaningful; the rest aliases
    assign unused_addr_bits = ^{umai.wcmd_addr, umai.rcmd_addr};

    assign idle            = (state == StIdle);
    assign umai.wcmd_ready = idle && (!umai.rcmd_valid || prio == PrioWr);
    assign umai.rcmd_ready = idle && (!umai.wcmd_valid || prio == PrioRd);
    assign wr_acc          = umai.wcmd_valid && umai.wcmd_ready;
    assign rd_acc          = umai.rcmd_valid && umai.rcmd_ready;

    assign umai.wready = (state == StWrite);
    assign wr_beat     = (state == StWrite) && umai.wvalid;
    assign rd_issue    = (state == StRead) && (!vld_p1 || umai.rready);

    umai_mem_responder_mem #(
        .DepthLog2 (DepthLog2)
    ) u_mem (
        .clk   (i_clk),
        .we    (wr_beat),
        .waddr (ptr),
        .wdata (umai.wdata),
        .raddr (ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= StIdle;
            prio  <= PrioWr;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            // Fairness only matters when both commands compete in the same cycle
            if (umai.wcmd_valid && umai.rcmd_valid && (wr_acc || rd_acc)) begin
                prio <= ~prio;
            end
            case (state)
                StIdle: begin
                    if (wr_acc) begin
                        state <= StWrite;
                        ptr   <= beat_index(umai.wcmd_addr);
                        cnt   <= umai.wcmd_len;
                    end else if (rd_acc) begin
                        state <= StRead;
                        ptr   <= beat_index(umai.rcmd_addr);
                        cnt   <= umai.rcmd_len;
                    end
                end
                StWrite: begin
                    if (wr_beat) begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state <= StIdle;
                        end
                    end
                end
                StRead: begin
                    if (rd_issue) begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Stage p1: registered read beat, held while the master stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else if (rd_issue) begin
            vld_p1   <= 1'b1;
            rdata_p1 <= mem_rdata;
        end else if (umai.rready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign umai.rvalid = vld_p1;
    assign umai.rdata  = rdata_p1;
    assign o_busy      = !idle || vld_p1;

endmodule

// File: tb/tb_umai_mem_responder.sv
// Self-checking bench for umai_mem_responder: randomized beats against an array model
// of the 64-entry beat memory plus directed arbitration, wrap, alias and reset scenarios.
module tb_umai_mem_responder;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    logic [511:0] model [DEPTH];

    umai_mem_responder_if bus ();

    umai_mem_responder #(
        .DepthLog2 (6)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .umai    (bus),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr >> 6) % DEPTH);
    endfunction

    task automatic do_write(input logic [31:0] addr, input int len);
        bit ok;
        int idx;
        @(negedge clk);
        bus.wcmd_valid = 1'b1;
        bus.wcmd_addr  = addr;
        bus.wcmd_len   = 6'(len);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (bus.wcmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wcmd_accept addr=%h: ready never seen, required 1", addr);
            bus.wcmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.wcmd_valid = 1'b0;
        idx = idx_of(addr);
        for (int b = 0; b <= len; b++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = rand512();
            #1;
            checks++;
            if (bus.wready !== 1'b1) begin
                errors++;
                $display("FAIL wready beat %0d: got %b required 1", b, bus.wready);
            end
            model[idx] = bus.wdata;
            idx = (idx + 1) % DEPTH;
            @(posedge clk);
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        #1;
        checks++;
        if (bus.wcmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wcmd_ready_after_write: got %b required 1", bus.wcmd_ready);
        end
    endtask

    // mode 0: rready always 1, 1: alternating 1/0, 2: random
    task automatic do_read(input logic [31:0] addr, input int len, input int mode);
        bit ok;
        bit prev_stall;
        logic [511:0] prev_data;
        logic [511:0] exp;
        int got;
        int acc;
        @(negedge clk);
        bus.rcmd_valid = 1'b1;
        bus.rcmd_addr  = addr;
        bus.rcmd_len   = 6'(len);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (bus.rcmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rcmd_accept addr=%h: ready never seen, required 1", addr);
            bus.rcmd_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(posedge clk);
        got = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int c = 0; c < 400 && got <= len; c++) begin
            @(negedge clk);
            bus.rcmd_valid = 1'b0;
            case (mode)
                0: bus.rready = 1'b1;
                1: bus.rready = (c % 2 == 0);
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (prev_stall) begin
                checks++;
                if (bus.rvalid !== 1'b1 || bus.rdata !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold beat %0d: rvalid=%b rdata=%h required rvalid=1 rdata=%h",
                             got, bus.rvalid, bus.rdata, prev_data);
                end
            end
            if (bus.rvalid === 1'b1 && bus.rready === 1'b1) begin
                exp = model[(idx_of(addr) + got) % DEPTH];
                checks++;
                if (bus.rdata !== exp) begin
                    errors++;
                    $display("FAIL rdata beat %0d: got %h required %h", got, bus.rdata, exp);
                end
                if (got == 0 && mode == 0) begin
                    checks++;
                    if (cyc - acc != 2) begin
                        errors++;
                        $display("FAIL first_rvalid_latency: got %0d required 2", cyc - acc);
                    end
                end
                got++;
            end
            prev_stall = (bus.rvalid === 1'b1) && (bus.rready !== 1'b1);
            prev_data  = bus.rdata;
        end
        checks++;
        if (got != len + 1) begin
            errors++;
            $display("FAIL read_beat_count addr=%h: got %0d required %0d", addr, got, len + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bus.rvalid !== 1'b0 || bus.wready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b rvalid=%b wready=%b required 0 0 0", busy, bus.rvalid, bus.wready);
        end
        checks++;
        if (bus.rdata !== 512'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 0", bus.rdata);
        end
        checks++;
        if (bus.wcmd_ready !== 1'b1 || bus.rcmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: wcmd=%b rcmd=%b required 1 1", bus.wcmd_ready, bus.rcmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_collision();
        logic [511:0] d0;
        logic [511:0] d1;
        bit ok;
        d0 = rand512();
        d1 = rand512();
        // First collision out of reset: write wins
        @(negedge clk);
        bus.wcmd_valid = 1'b1; bus.wcmd_addr = 32'h80; bus.wcmd_len = 6'd0;
        bus.rcmd_valid = 1'b1; bus.rcmd_addr = 32'h80; bus.rcmd_len = 6'd0;
        #1;
        checks++;
        if (bus.wcmd_ready !== 1'b1 || bus.rcmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll1_ready: wcmd=%b rcmd=%b required 1 0", bus.wcmd_ready, bus.rcmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.wcmd_valid = 1'b0;
        bus.wvalid = 1'b1;
        bus.wdata  = d0;
        #1;
        checks++;
        if (bus.rcmd_ready !== 1'b0 || bus.wready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL coll1_write_phase: rcmd_ready=%b wready=%b busy=%b required 0 1 1",
                     bus.rcmd_ready, bus.wready, busy);
        end
        @(posedge clk);
        @(negedge clk);
        bus.wvalid = 1'b0;
        model[2] = d0;
        #1;
        checks++;
        if (bus.rcmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll1_read_next: rcmd_ready=%b required 1", bus.rcmd_ready);
        end
        @(posedge clk);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.rcmd_valid = 1'b0;
            bus.rready = 1'b1;
            #1;
            if (bus.rvalid === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || bus.rdata !== d0) begin
            errors++;
            $display("FAIL coll1_rdata: rvalid_seen=%b rdata=%h required %h", ok, bus.rdata, d0);
        end
        // Second collision: read now has priority
        @(negedge clk);
        bus.wcmd_valid = 1'b1; bus.wcmd_addr = 32'hC0; bus.wcmd_len = 6'd0;
        bus.rcmd_valid = 1'b1; bus.rcmd_addr = 32'h80; bus.rcmd_len = 6'd0;
        #1;
        checks++;
        if (bus.rcmd_ready !== 1'b1 || bus.wcmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll2_ready: wcmd=%b rcmd=%b required 0 1", bus.wcmd_ready, bus.rcmd_ready);
        end
        @(posedge clk);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.rcmd_valid = 1'b0;
            bus.rready = 1'b1;
            #1;
            if (bus.rvalid === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || bus.rdata !== d0) begin
            errors++;
            $display("FAIL coll2_rdata: rvalid_seen=%b rdata=%h required %h", ok, bus.rdata, d0);
        end
        // Last read beat already issued, so the waiting write is acceptable now
        checks++;
        if (bus.wcmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll2_write_next: wcmd_ready=%b required 1", bus.wcmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.wcmd_valid = 1'b0;
        bus.wvalid = 1'b1;
        bus.wdata  = d1;
        @(posedge clk);
        @(negedge clk);
        bus.wvalid = 1'b0;
        model[3] = d1;
        do_read(32'hC0, 0, 0);
    endtask

    task automatic test_basic();
        do_write(32'h40, 3);
        do_read(32'h40, 3, 0);
    endtask

    task automatic test_stall();
        do_write(32'h100, 7);
        do_read(32'h100, 7, 1);
    endtask

    task automatic test_wrap();
        do_write(32'hFC0, 1);
        do_read(32'hFC0, 1, 0);
        do_read(32'h0, 0, 0);
        do_write(32'hFC0, 63);
        do_read(32'hFC0, 63, 2);
    endtask

    task automatic test_alias();
        do_write(32'h8000_0040, 0);
        do_read(32'h40, 0, 0);
        do_read(32'hFFFF_F040, 0, 1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        int len;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            len = $urandom_range(0, 15);
            do_write(a, len);
            do_read(a, $urandom_range(0, len), 2);
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int got;
        do_write(32'h400, 7);
        @(negedge clk);
        bus.rcmd_valid = 1'b1; bus.rcmd_addr = 32'h400; bus.rcmd_len = 6'd7;
        #1;
        checks++;
        if (bus.rcmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_accept: rcmd_ready=%b required 1", bus.rcmd_ready);
        end
        @(posedge clk);
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            bus.rcmd_valid = 1'b0;
            bus.rready = 1'b1;
            #1;
            if (bus.rvalid === 1'b1) begin
                checks++;
                if (bus.rdata !== model[16 + got]) begin
                    errors++;
                    $display("FAIL mid_read_beat %0d: got %h required %h", got, bus.rdata, model[16 + got]);
                end
                got++;
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rvalid !== 1'b0 || busy !== 1'b0 || bus.wready !== 1'b0 || bus.rdata !== 512'd0) begin
            errors++;
            $display("FAIL mid_read_reset: rvalid=%b busy=%b wready=%b rdata_zero=%b required 0 0 0 1",
                     bus.rvalid, busy, bus.wready, (bus.rdata === 512'd0));
        end
        checks++;
        if (bus.wcmd_ready !== 1'b1 || bus.rcmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_reset_ready: wcmd=%b rcmd=%b required 1 1", bus.wcmd_ready, bus.rcmd_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_write(32'h600, 0);
        do_read(32'h600, 0, 0);
        do_read(32'h400, 7, 0);
    endtask

    initial begin
        bus.wcmd_valid = 1'b0; bus.wcmd_addr = '0; bus.wcmd_len = '0;
        bus.rcmd_valid = 1'b0; bus.rcmd_addr = '0; bus.rcmd_len = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.rready = 1'b0;
        test_reset();
        test_collision();
        test_basic();
        test_stall();
        test_wrap();
        test_alias();
        test_random();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
